alu_mul_sequencer: RTL and testbench

- Multi-cycle 32x32 -> 64-bit multiply controller. Implements shift-add multiplication by driving the existing shared 32-bit ALU's operand and op-select inputs, one ALU operation per cycle.
- Sits beside the ALU in the datapath. It owns the ALU only while busy; outside busy it drives neutral values.
- Supports unsigned and signed (two's-complement) operands through a start/busy/done handshake.

---
 rtl/alu_mul_sequencer_pkg.sv | 13 +
 rtl/alu_mul_sequencer.sv | 108 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// alu_mul_sequencer_pkg: ALU op codes, sizes and FSM states shared by the multiply sequencer
package alu_mul_sequencer_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_NEG_LO, S_NEG_HI, S_DONE
  } state_t;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 32x32->64 shift-add multiply that borrows the shared ALU one op per cycle
// Ports: clk/rst_n (async active-low); start/is_signed/op_a/op_b request;
// busy/done handshake; prod_hi/prod_lo product; alu_dataA/alu_dataB/alu_signal drive
// the ALU, alu_result is its combinational result.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] alu_dataA,
  output logic [WIDTH-1:0] alu_dataB,
  output logic [2:0]       alu_signal,
  input  logic [WIDTH-1:0] alu_result
);
  state_t state, nxt;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic sgn, neg_res, lo_zero;
  // The ALU has no carry-out, so recover it from the unsigned wrap of prod_hi + mcand.
  logic carry;
  assign carry = alu_result < prod_hi;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    alu_dataA = '0;
    alu_dataB = '0;
    alu_signal = ALU_AND;
    case (state)
      S_IDLE: nxt = start ? (is_signed ? S_NEG_A : S_ITER) : S_IDLE;
      S_NEG_A: begin
        alu_signal = ALU_SUB;
        alu_dataB = mcand;
        nxt = S_NEG_B;
      end
      S_NEG_B: begin
        alu_signal = ALU_SUB;
        alu_dataB = prod_lo;
        nxt = S_ITER;
      end
      S_ITER: begin
        alu_signal = ALU_ADD;
        alu_dataA = prod_hi;
        alu_dataB = mcand;
        nxt = cnt == CNT_W'(WIDTH - 1) ? (sgn ? S_NEG_LO : S_DONE) : S_ITER;
      end
      S_NEG_LO: begin
        alu_signal = ALU_SUB;
        alu_dataB = prod_lo;
        nxt = S_NEG_HI;
      end
      // Upper half of a 64-bit negate: ~hi plus the borrow-free carry from a zero low word.
      S_NEG_HI: begin
        alu_signal = ALU_ADD;
        alu_dataA = ~prod_hi;
        alu_dataB = {{(WIDTH-1){1'b0}}, lo_zero};
        nxt = S_DONE;
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      neg_res <= 1'b0;
      lo_zero <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (start) begin
            mcand <= op_a;
            prod_lo <= op_b;
            prod_hi <= '0;
            cnt <= '0;
            sgn <= is_signed;
            neg_res <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          end
        S_NEG_A: if (sgn && mcand[WIDTH-1]) mcand <= alu_result;
        S_NEG_B: if (sgn && prod_lo[WIDTH-1]) prod_lo <= alu_result;
        S_ITER: begin
          {prod_hi, prod_lo} <= prod_lo[0] ? {carry, alu_result, prod_lo[WIDTH-1:1]}
                                           : {1'b0, prod_hi, prod_lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_NEG_LO: begin
          lo_zero <= prod_lo == '0;
          if (neg_res) prod_lo <= alu_result;
        end
        S_NEG_HI: if (neg_res) prod_hi <= alu_result;
        default: ;
      endcase
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: random and directed multiplies against a 64-bit arithmetic reference
module tb_alu_mul_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic is_signed = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic busy, done;
  logic [31:0] prod_hi, prod_lo, alu_dataA, alu_dataB, alu_result;
  logic [2:0] alu_signal;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .alu_result(alu_result)
  );
  always_comb
    case (alu_signal)
      3'b000: alu_result = alu_dataA & alu_dataB;
      3'b001: alu_result = alu_dataA | alu_dataB;
      3'b010: alu_result = alu_dataA + alu_dataB;
      3'b110: alu_result = alu_dataA - alu_dataB;
      3'b111: alu_result = {31'b0, $signed(alu_dataA) < $signed(alu_dataB)};
      default: alu_result = '0;
    endcase
  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic s);
    logic [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'b0, a};
    y = s ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(logic [31:0] a, logic [31:0] b, logic s);
    @(negedge clk);
    start = 1'b1;
    op_a = a;
    op_b = b;
    is_signed = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    is_signed = 1'($urandom);
  endtask
  // Waits for done after an accepted start; with poke, stray starts are driven mid-run
  // and in the done cycle, the latter carrying the next operands so it stays high into IDLE.
  task automatic finish_op(string tag, logic [31:0] a, logic [31:0] b, logic s, logic poke,
                           logic [31:0] na, logic [31:0] nb, logic ns);
    int lat, got_lat;
    logic busy_ok;
    logic [63:0] exp;
    exp = ref_mul(a, b, s);
    lat = s ? 37 : 33;
    got_lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (poke) begin
        start = n == 5;
        if (n == 5) begin
          op_a = $urandom;
          op_b = $urandom;
          is_signed = 1'($urandom);
        end
      end
      if (done) begin
        got_lat = n;
        break;
      end
    end
    if (poke) begin
      start = 1'b1;
      op_a = na;
      op_b = nb;
      is_signed = ns;
    end
    check({tag, " latency"}, 64'(got_lat), 64'(lat));
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    check({tag, " product"}, {prod_hi, prod_lo}, exp);
    @(negedge clk);
    check({tag, " idle busy/done"}, {62'b0, busy, done}, 64'd0);
    check({tag, " held"}, {prod_hi, prod_lo}, exp);
    check({tag, " alu neutral"}, {alu_dataA[15:0], alu_dataB[15:0], 29'b0, alu_signal},
          64'd0);
    if (poke) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask
  task automatic run_op(string tag, logic [31:0] a, logic [31:0] b, logic s);
    launch(a, b, s);
    finish_op(tag, a, b, s, 1'b0, '0, '0, 1'b0);
  endtask
  initial begin
    logic saw_done;
    #2;
    check("reset outputs", {30'b0, busy, done, prod_hi | prod_lo}, 64'd0);
    check("reset alu", {alu_dataA, alu_dataB | {29'b0, alu_signal}}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("u 6x7", 32'd6, 32'd7, 1'b0);
    run_op("u max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("s -3x5", 32'hFFFFFFFD, 32'd5, 1'b1);
    run_op("s min*min", 32'h80000000, 32'h80000000, 1'b1);
    run_op("s min*1", 32'h80000000, 32'd1, 1'b1);
    run_op("s 0*-1", 32'd0, 32'hFFFFFFFF, 1'b1);
    run_op("s -1*-1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    launch(32'd1234, 32'd5678, 1'b0);
    finish_op("poke", 32'd1234, 32'd5678, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd11, 1'b1);
    finish_op("after poke", 32'hFFFFFFF9, 32'd11, 1'b1, 1'b0, '0, '0, 1'b0);
    launch($urandom, $urandom, 1'b1);
    saw_done = 1'b0;
    for (int n = 1; n < 10; n++) begin
      @(negedge clk);
      saw_done |= done;
    end
    rst_n = 1'b0;
    #1;
    check("abort outputs", {30'b0, busy, done, prod_hi | prod_lo}, 64'd0);
    check("abort alu", {alu_dataA, alu_dataB | {29'b0, alu_signal}}, 64'd0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      saw_done |= done | busy;
    end
    check("abort no done", 64'(saw_done), 64'd0);
    rst_n = 1'b1;
    run_op("post reset 2x3", 32'd2, 32'd3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      if (i % 5 == 0) a = {a[31], 31'($urandom_range(0, 3))};
      run_op($sformatf("rand%0d", i), a, b, s);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
